// File: rtl/ace_snoop_responder_if.sv
// rtl/ace_snoop_responder_if.sv - AC/CR/CD snoop channel bundle between snoop crossbar and responder
interface ace_snoop_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  ac_valid_i;
    logic                  ac_ready_o;
    logic [ADDR_WIDTH-1:0] ac_addr_i;
    logic [3:0]            ac_snoop_i;
    logic [2:0]            ac_prot_i;
    logic                  cr_valid_o;
    logic                  cr_ready_i;
    logic [4:0]            cr_resp_o;
    logic                  cd_valid_o;
    logic                  cd_ready_i;
    logic [DATA_WIDTH-1:0] cd_data_o;
    logic                  cd_last_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
        output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
        input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// rtl/ace_snoop_responder.sv - ACE snoop responder: tag lookup, CRRESP, CD line stream, state update
// One snoop in flight; every handshake output is registered and held until its grant/ready.
module ace_snoop_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int CD_BEATS   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ace_snoop_responder_if.slave  snp,
    output logic                  tag_req_o,
    input  logic                  tag_gnt_i,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    input  logic                  tag_rvalid_i,
    input  logic                  tag_hit_i,
    input  logic                  tag_dirty_i,
    input  logic                  tag_shared_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  upd_req_o,
    input  logic                  upd_gnt_i,
    output logic [ADDR_WIDTH-1:0] upd_addr_o,
    output logic                  upd_valid_o,
    output logic                  upd_dirty_o,
    output logic                  upd_shared_o
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(CD_BEATS * BEAT_BYTES);
    localparam int CNT_W      = $clog2(CD_BEATS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CD_BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESP, S_DATA, S_UPDATE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] line_q;
    logic [3:0]            snoop_q;
    logic [2:0]            prot_unused_q;
    logic                  upd_need_q;
    logic [CNT_W-1:0]      beat_q;
    logic                  cr_valid_q;
    logic [4:0]            cr_resp_q;
    logic                  cd_valid_q;
    logic [DATA_WIDTH-1:0] cd_data_q;
    logic                  cd_last_q;

    assign snp.ac_ready_o = (state_q == S_IDLE);
    assign snp.cr_valid_o = cr_valid_q;
    assign snp.cr_resp_o  = cr_resp_q;
    assign snp.cd_valid_o = cd_valid_q;
    assign snp.cd_data_o  = cd_data_q;
    assign snp.cd_last_o  = cd_last_q;

    // Response decode from the captured snoop and the live tag result; keep_c means the line
    // survives as valid+shared+clean, otherwise an update invalidates it.
    logic [4:0] resp_c;
    logic       upd_c, keep_c, dt_c, pd_c, is_c, err_c;

    always_comb begin
        dt_c   = 1'b0;
        pd_c   = 1'b0;
        is_c   = 1'b0;
        err_c  = 1'b0;
        upd_c  = 1'b0;
        keep_c = 1'b0;
        resp_c = 5'b00000;
        case (snoop_q)
            4'b0000: begin dt_c = 1'b1; is_c = 1'b1; end
            4'b0001, 4'b0010, 4'b0011: begin
                dt_c = 1'b1; pd_c = tag_dirty_i; is_c = 1'b1; upd_c = 1'b1; keep_c = 1'b1;
            end
            4'b0111, 4'b1001: begin dt_c = 1'b1; pd_c = tag_dirty_i; upd_c = 1'b1; end
            4'b1000: begin
                dt_c = tag_dirty_i; pd_c = tag_dirty_i; is_c = 1'b1; upd_c = 1'b1; keep_c = 1'b1;
            end
            4'b1101: upd_c = 1'b1;
            default: err_c = 1'b1;
        endcase
        if (err_c) begin
            resp_c = 5'b00010;
        end else if (!tag_hit_i) begin
            upd_c = 1'b0;
        end else begin
            resp_c = {!tag_shared_i, is_c, pd_c, 1'b0, dt_c};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            line_q        <= '0;
            snoop_q       <= '0;
            prot_unused_q <= '0;
            upd_need_q    <= 1'b0;
            beat_q        <= '0;
            cr_valid_q    <= 1'b0;
            cr_resp_q     <= '0;
            cd_valid_q    <= 1'b0;
            cd_data_q     <= '0;
            cd_last_q     <= 1'b0;
            tag_req_o     <= 1'b0;
            tag_addr_o    <= '0;
            data_req_o    <= 1'b0;
            data_addr_o   <= '0;
            upd_req_o     <= 1'b0;
            upd_addr_o    <= '0;
            upd_valid_o   <= 1'b0;
            upd_dirty_o   <= 1'b0;
            upd_shared_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (snp.ac_valid_i) begin
                    line_q        <= snp.ac_addr_i & LINE_MASK;
                    snoop_q       <= snp.ac_snoop_i;
                    prot_unused_q <= snp.ac_prot_i;
                    tag_req_o     <= 1'b1;
                    tag_addr_o    <= snp.ac_addr_i & LINE_MASK;
                    state_q       <= S_LOOKUP;
                end
                // A dropped tag_req_o marks the grant; the result is only accepted after it.
                S_LOOKUP: if (tag_req_o) begin
                    if (tag_gnt_i) tag_req_o <= 1'b0;
                end else if (tag_rvalid_i) begin
                    cr_valid_q   <= 1'b1;
                    cr_resp_q    <= resp_c;
                    upd_need_q   <= upd_c;
                    upd_addr_o   <= line_q;
                    upd_valid_o  <= keep_c;
                    upd_shared_o <= keep_c;
                    upd_dirty_o  <= 1'b0;
                    state_q      <= S_RESP;
                end
                S_RESP: if (snp.cr_ready_i) begin
                    cr_valid_q <= 1'b0;
                    if (cr_resp_q[0]) begin
                        beat_q      <= '0;
                        data_req_o  <= 1'b1;
                        data_addr_o <= line_q;
                        state_q     <= S_DATA;
                    end else if (upd_need_q) begin
                        upd_req_o <= 1'b1;
                        state_q   <= S_UPDATE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                // Per beat: request until grant, wait for read data, present on CD until taken.
                S_DATA: if (data_req_o) begin
                    if (data_gnt_i) data_req_o <= 1'b0;
                end else if (cd_valid_q) begin
                    if (snp.cd_ready_i) begin
                        cd_valid_q <= 1'b0;
                        cd_last_q  <= 1'b0;
                        if (cd_last_q) begin
                            upd_req_o <= upd_need_q;
                            state_q   <= upd_need_q ? S_UPDATE : S_IDLE;
                        end else begin
                            beat_q      <= beat_q + CNT_W'(1);
                            data_req_o  <= 1'b1;
                            data_addr_o <= data_addr_o + ADDR_WIDTH'(BEAT_BYTES);
                        end
                    end
                end else if (data_rvalid_i) begin
                    cd_valid_q <= 1'b1;
                    cd_data_q  <= data_rdata_i;
                    cd_last_q  <= (beat_q == LAST_BEAT);
                end
                S_UPDATE: if (upd_gnt_i) begin
                    upd_req_o <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb/tb_ace_snoop_responder.sv - randomized self-checking bench for ace_snoop_responder
module tb_ace_snoop_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ace_snoop_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) snp();
    logic        tag_req, tag_gnt, tag_rvalid, tag_hit, tag_dirty, tag_shared;
    logic [63:0] tag_addr;
    logic        data_req, data_gnt, data_rvalid;
    logic [63:0] data_addr, data_rdata;
    logic        upd_req, upd_gnt, upd_valid, upd_dirty, upd_shared;
    logic [63:0] upd_addr;

    ace_snoop_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .CD_BEATS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .snp(snp),
        .tag_req_o(tag_req), .tag_gnt_i(tag_gnt), .tag_addr_o(tag_addr),
        .tag_rvalid_i(tag_rvalid), .tag_hit_i(tag_hit), .tag_dirty_i(tag_dirty),
        .tag_shared_i(tag_shared),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .upd_req_o(upd_req), .upd_gnt_i(upd_gnt), .upd_addr_o(upd_addr),
        .upd_valid_o(upd_valid), .upd_dirty_o(upd_dirty), .upd_shared_o(upd_shared)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [4:0]  obs_resp;
    logic [63:0] obs_cd_data[$];
    logic        obs_cd_last[$];
    logic [63:0] obs_data_addr[$];
    logic [63:0] obs_tag_addr, obs_upd_addr;
    logic        obs_upd_v, obs_upd_d, obs_upd_s;
    int          obs_upd_cnt, obs_proto_err, obs_latency;
    bit          obs_timeout, obs_cd_before_cr, obs_aborted;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
    endfunction

    // Reference: snoop rule table -> expected CRRESP, CD beat count, update and new state.
    function automatic void model(input logic [3:0] s, input logic h, d, sh,
                                  output logic [4:0] resp, output int beats,
                                  output bit upd, output logic nv, output logic ns);
        logic dt, pd, is_;
        dt = 0; pd = 0; is_ = 0; upd = 0; nv = 0; ns = 0; beats = 0; resp = 5'b00000;
        case (s)
            4'b0000: begin dt = 1; is_ = 1; end
            4'b0001, 4'b0010, 4'b0011: begin dt = 1; pd = d; is_ = 1; upd = 1; nv = 1; ns = 1; end
            4'b0111, 4'b1001: begin dt = 1; pd = d; upd = 1; end
            4'b1000: begin dt = d; pd = d; is_ = 1; upd = 1; nv = 1; ns = 1; end
            4'b1101: upd = 1;
            default: begin resp = 5'b00010; return; end
        endcase
        if (!h) begin upd = 0; return; end
        resp  = {!sh, is_, pd, 1'b0, dt};
        beats = dt ? 4 : 0;
    endfunction

    task automatic do_snoop(input logic [3:0] snoop, input logic [63:0] addr,
                            input logic hit, dirty, shared, input int stall, input int abort_beat);
        bit   ac_done = 0, cr_done = 0, tag_granted = 0, tag_rv_sent = 0, data_granted = 0, done = 0;
        int   tag_dly = 0, data_dly = 0, ac_cyc = 0;
        logic [63:0] gnt_addr = '0;
        logic prev_crv = 0, prev_cr_hs = 0, prev_cdv = 0, prev_cd_hs = 0, prev_cdl = 0;
        logic [4:0]  prev_resp = '0;
        logic [63:0] prev_cdd = '0;
        obs_cd_data.delete(); obs_cd_last.delete(); obs_data_addr.delete();
        obs_resp = '0; obs_upd_cnt = 0; obs_proto_err = 0; obs_latency = 0; obs_tag_addr = '0;
        obs_timeout = 0; obs_cd_before_cr = 0; obs_aborted = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (prev_crv && !prev_cr_hs && (!snp.cr_valid_o || snp.cr_resp_o !== prev_resp))
                obs_proto_err++;
            if (prev_cdv && !prev_cd_hs && (!snp.cd_valid_o || snp.cd_data_o !== prev_cdd ||
                                            snp.cd_last_o !== prev_cdl))
                obs_proto_err++;
            if (abort_beat >= 0 && snp.cd_valid_o && obs_cd_data.size() == abort_beat) begin
                obs_aborted = 1;
                break;
            end
            done = cr_done && snp.ac_ready_o;
            snp.cr_ready_i = ($urandom_range(99) >= stall);
            snp.cd_ready_i = ($urandom_range(99) >= stall);
            tag_gnt = 0; tag_rvalid = 0; data_gnt = 0; data_rvalid = 0; upd_gnt = 0;
            snp.ac_valid_i = !ac_done;
            snp.ac_addr_i  = addr;
            snp.ac_snoop_i = snoop;
            snp.ac_prot_i  = 3'($urandom);
            if (!ac_done && snp.ac_ready_o) begin ac_done = 1; ac_cyc = cyc; end
            if (tag_granted && !tag_rv_sent) begin
                if (tag_dly == 0) begin
                    tag_rvalid = 1; tag_hit = hit; tag_dirty = dirty; tag_shared = shared;
                    tag_rv_sent = 1;
                end else tag_dly--;
            end
            if (tag_req && !tag_granted && $urandom_range(99) >= stall) begin
                tag_gnt = 1; tag_granted = 1; tag_dly = $urandom_range(2); obs_tag_addr = tag_addr;
            end
            if (data_granted) begin
                if (data_dly == 0) begin
                    data_rvalid = 1; data_rdata = mem_word(gnt_addr); data_granted = 0;
                end else data_dly--;
            end
            if (data_req && !data_granted && !data_rvalid && $urandom_range(99) >= stall) begin
                data_gnt = 1; data_granted = 1; data_dly = $urandom_range(2);
                gnt_addr = data_addr; obs_data_addr.push_back(data_addr);
            end
            if (snp.cd_valid_o && snp.cd_ready_i) begin
                if (!cr_done) obs_cd_before_cr = 1;
                obs_cd_data.push_back(snp.cd_data_o);
                obs_cd_last.push_back(snp.cd_last_o);
            end
            if (snp.cr_valid_o && snp.cr_ready_i && !cr_done) begin
                cr_done = 1; obs_resp = snp.cr_resp_o; obs_latency = cyc - ac_cyc;
            end
            if (upd_req && $urandom_range(99) >= stall) begin
                upd_gnt = 1; obs_upd_cnt++; obs_upd_addr = upd_addr;
                obs_upd_v = upd_valid; obs_upd_d = upd_dirty; obs_upd_s = upd_shared;
            end
            prev_crv = snp.cr_valid_o; prev_cr_hs = snp.cr_valid_o && snp.cr_ready_i;
            prev_resp = snp.cr_resp_o;
            prev_cdv = snp.cd_valid_o; prev_cd_hs = snp.cd_valid_o && snp.cd_ready_i;
            prev_cdd = snp.cd_data_o; prev_cdl = snp.cd_last_o;
        end
        if (!done && !obs_aborted) obs_timeout = 1;
        snp.ac_valid_i = 0; snp.cr_ready_i = 0; snp.cd_ready_i = 0;
        tag_gnt = 0; tag_rvalid = 0; data_gnt = 0; data_rvalid = 0; upd_gnt = 0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({snp.cr_valid_o, snp.cd_valid_o, tag_req, data_req, upd_req, snp.cd_last_o} !== 6'b0)
            $display("FAIL reset_valids: got %b expected 000000",
                     {snp.cr_valid_o, snp.cd_valid_o, tag_req, data_req, upd_req, snp.cd_last_o});
        else n_pass++;
        n_total++;
        if (snp.ac_ready_o !== 1'b1) $display("FAIL reset_ac_ready: got %b expected 1", snp.ac_ready_o);
        else n_pass++;
        n_total++;
        if ({snp.cr_resp_o, snp.cd_data_o} !== 69'b0)
            $display("FAIL reset_payload: got %h/%h expected 0/0", snp.cr_resp_o, snp.cd_data_o);
        else n_pass++;
        n_total++;
        if ({tag_addr, data_addr, upd_addr, upd_valid, upd_dirty, upd_shared} !== 195'b0)
            $display("FAIL reset_cache_ports: got %h %h %h expected 0", tag_addr, data_addr, upd_addr);
        else n_pass++;
    endtask

    task automatic test_read_shared_dirty();
        do_snoop(4'b0001, 64'h0000_1234_5678_9ABC, 1, 1, 0, 30, -1);
        n_total++;
        if (obs_resp !== 5'b11101) $display("FAIL rs_dirty_resp: got %b expected 11101", obs_resp);
        else n_pass++;
        n_total++;
        if (obs_cd_data.size() != 4) $display("FAIL rs_dirty_beats: got %0d expected 4", obs_cd_data.size());
        else n_pass++;
        n_total++;
        if (obs_cd_data.size() != 4 || {obs_cd_last[3], obs_cd_last[2], obs_cd_last[1], obs_cd_last[0]} !== 4'b1000)
            $display("FAIL rs_dirty_last: got beats=%0d expected last only on beat 3", obs_cd_data.size());
        else n_pass++;
        n_total++;
        if (obs_upd_cnt != 1 || {obs_upd_v, obs_upd_d, obs_upd_s} !== 3'b101)
            $display("FAIL rs_dirty_update: got cnt=%0d vds=%b%b%b expected cnt=1 vds=101",
                     obs_upd_cnt, obs_upd_v, obs_upd_d, obs_upd_s);
        else n_pass++;
        n_total++;
        if (obs_upd_addr !== 64'h0000_1234_5678_9AA0)
            $display("FAIL rs_dirty_upd_addr: got %h expected 0000123456789aa0", obs_upd_addr);
        else n_pass++;
    endtask

    task automatic test_read_unique_clean_shared();
        do_snoop(4'b0111, 64'h0000_0000_0000_4040, 1, 0, 1, 30, -1);
        n_total++;
        if (obs_resp !== 5'b00001) $display("FAIL ru_resp: got %b expected 00001", obs_resp);
        else n_pass++;
        n_total++;
        if (obs_cd_data.size() != 4) $display("FAIL ru_beats: got %0d expected 4", obs_cd_data.size());
        else n_pass++;
        n_total++;
        if (obs_upd_cnt != 1 || obs_upd_v !== 1'b0)
            $display("FAIL ru_update: got cnt=%0d v=%b expected cnt=1 v=0", obs_upd_cnt, obs_upd_v);
        else n_pass++;
    endtask

    task automatic test_miss();
        logic [3:0] legal[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001, 4'b1000, 4'b1101};
        for (int i = 0; i < 8; i++) begin
            do_snoop(legal[i], {$urandom, $urandom}, 0, 1'($urandom), 1'($urandom), 20, -1);
            n_total++;
            if (obs_resp !== 5'b00000 || obs_data_addr.size() != 0 || obs_upd_cnt != 0 || obs_timeout)
                $display("FAIL miss_%b: got resp=%b dreq=%0d upd=%0d timeout=%0d expected 00000/0/0/0",
                         legal[i], obs_resp, obs_data_addr.size(), obs_upd_cnt, obs_timeout);
            else n_pass++;
        end
    endtask

    task automatic test_clean_shared();
        do_snoop(4'b1000, 64'h0000_0000_00FF_0008, 1, 0, 0, 30, -1);
        n_total++;
        if (obs_resp !== 5'b11000) $display("FAIL cs_resp: got %b expected 11000", obs_resp);
        else n_pass++;
        n_total++;
        if (obs_cd_data.size() != 0 || obs_data_addr.size() != 0)
            $display("FAIL cs_no_cd: got beats=%0d expected 0", obs_cd_data.size());
        else n_pass++;
        n_total++;
        if (obs_upd_cnt != 1 || {obs_upd_v, obs_upd_d, obs_upd_s} !== 3'b101)
            $display("FAIL cs_update: got cnt=%0d vds=%b%b%b expected cnt=1 vds=101",
                     obs_upd_cnt, obs_upd_v, obs_upd_d, obs_upd_s);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_snoop(4'b1111, 64'h0000_0000_0000_1000, 1, 1, 0, 30, -1);
        n_total++;
        if (obs_resp !== 5'b00010) $display("FAIL illegal_resp: got %b expected 00010", obs_resp);
        else n_pass++;
        n_total++;
        if (obs_cd_data.size() != 0 || obs_data_addr.size() != 0 || obs_upd_cnt != 0 || obs_timeout)
            $display("FAIL illegal_side_effects: got beats=%0d dreq=%0d upd=%0d timeout=%0d expected 0",
                     obs_cd_data.size(), obs_data_addr.size(), obs_upd_cnt, obs_timeout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] e_resp; int e_beats; bit e_upd; logic e_nv, e_ns;
        logic [3:0] s; logic [63:0] a, base; logic h, d, sh;
        for (int t = 0; t < 30; t++) begin
            s = 4'($urandom); a = {$urandom, $urandom}; base = a & ~64'h1F;
            h = ($urandom_range(3) != 0); d = 1'($urandom); sh = 1'($urandom);
            model(s, h, d, sh, e_resp, e_beats, e_upd, e_nv, e_ns);
            do_snoop(s, a, h, d, sh, $urandom_range(60), -1);
            n_total++;
            if (obs_timeout || obs_resp !== e_resp)
                $display("FAIL rnd%0d_resp snoop=%b: got %b timeout=%0d expected %b", t, s, obs_resp, obs_timeout, e_resp);
            else n_pass++;
            n_total++;
            if (obs_tag_addr !== base) $display("FAIL rnd%0d_tag_addr: got %h expected %h", t, obs_tag_addr, base);
            else n_pass++;
            n_total++;
            if (obs_cd_data.size() != e_beats || obs_data_addr.size() != e_beats)
                $display("FAIL rnd%0d_beats: got %0d/%0d expected %0d", t, obs_cd_data.size(), obs_data_addr.size(), e_beats);
            else n_pass++;
            for (int b = 0; b < e_beats && b < obs_cd_data.size() && b < obs_data_addr.size(); b++) begin
                n_total++;
                if (obs_cd_data[b] !== mem_word(base + 64'(8 * b)) || obs_cd_last[b] !== (b == 3) ||
                    obs_data_addr[b] !== base + 64'(8 * b))
                    $display("FAIL rnd%0d_beat%0d: got data=%h last=%b addr=%h expected %h/%b/%h", t, b,
                             obs_cd_data[b], obs_cd_last[b], obs_data_addr[b], mem_word(base + 64'(8 * b)),
                             (b == 3), base + 64'(8 * b));
                else n_pass++;
            end
            n_total++;
            if (obs_upd_cnt != int'(e_upd) ||
                (e_upd && ({obs_upd_v, obs_upd_d, obs_upd_s} !== {e_nv, 1'b0, e_ns} || obs_upd_addr !== base)))
                $display("FAIL rnd%0d_update: got cnt=%0d vds=%b%b%b addr=%h expected cnt=%0d vds=%b0%b addr=%h",
                         t, obs_upd_cnt, obs_upd_v, obs_upd_d, obs_upd_s, obs_upd_addr, e_upd, e_nv, e_ns, base);
            else n_pass++;
            n_total++;
            if (obs_proto_err != 0 || obs_cd_before_cr || obs_latency < 3)
                $display("FAIL rnd%0d_protocol: got unstable=%0d cd_before_cr=%0d latency=%0d expected 0/0/>=3",
                         t, obs_proto_err, obs_cd_before_cr, obs_latency);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_data();
        do_snoop(4'b0111, 64'h0000_0000_0ABC_0000, 1, 1, 0, 30, 2);
        n_total++;
        if (!obs_aborted) $display("FAIL abort_reached_beat2: got 0 expected 1");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({snp.cr_valid_o, snp.cd_valid_o, tag_req, data_req, upd_req, snp.cd_last_o} !== 6'b0 ||
            snp.cd_data_o !== 64'b0 || snp.cr_resp_o !== 5'b0 || snp.ac_ready_o !== 1'b1)
            $display("FAIL abort_outputs: got v=%b data=%h resp=%b ready=%b expected 000000/0/0/1",
                     {snp.cr_valid_o, snp.cd_valid_o, tag_req, data_req, upd_req, snp.cd_last_o},
                     snp.cd_data_o, snp.cr_resp_o, snp.ac_ready_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_snoop(4'b0001, 64'h0000_0000_0000_7760, 1, 0, 1, 30, -1);
        n_total++;
        if (obs_timeout || obs_resp !== 5'b01001 || obs_cd_data.size() != 4 || obs_upd_cnt != 1)
            $display("FAIL after_abort: got resp=%b beats=%0d upd=%0d timeout=%0d expected 01001/4/1/0",
                     obs_resp, obs_cd_data.size(), obs_upd_cnt, obs_timeout);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        snp.ac_valid_i = 0; snp.ac_addr_i = '0; snp.ac_snoop_i = '0; snp.ac_prot_i = '0;
        snp.cr_ready_i = 0; snp.cd_ready_i = 0;
        tag_gnt = 0; tag_rvalid = 0; tag_hit = 0; tag_dirty = 0; tag_shared = 0;
        data_gnt = 0; data_rvalid = 0; data_rdata = '0; upd_gnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_read_shared_dirty();
        test_read_unique_clean_shared();
        test_miss();
        test_clean_shared();
        test_illegal();
        test_random();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
